// File: rtl/udp_pkg.sv
// Shared UDP definitions: FSM states, header layout and 16-bit field types,
// common to the UDP receive and transmit stages.
package udp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        PAYLOAD,
        DROP
    } state_t;

    typedef logic [15:0] udp_port_t;
    typedef logic [15:0] udp_len_t;

    localparam int UDP_HDR_BYTES = 8;
    localparam int SRC_OFF       = 0;
    localparam int DST_OFF       = 2;
    localparam int LEN_OFF       = 4;
    localparam int CSUM_OFF      = 6;

endpackage

// File: rtl/udp_hdr_capture.sv
// Stores UDP header bytes 0-5 by byte index and latches the big-endian fields
// when the deframer accepts the header.
module udp_hdr_capture
    import udp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data,
    input  logic        wr,
    input  logic [2:0]  idx,
    input  logic        latch,
    output logic [15:0] dst_now,
    output logic [15:0] len_now,
    output logic [15:0] src_port,
    output logic [15:0] dst_port,
    output logic [15:0] udp_length
);

    logic [CSUM_OFF-1:0][7:0] hb;

    // dst_now is valid while the dst low byte is on the input; len_now once bytes 4-5 are stored
    assign dst_now = {hb[DST_OFF], data};
    assign len_now = {hb[LEN_OFF], hb[LEN_OFF+1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            hb         <= '0;
            src_port   <= '0;
            dst_port   <= '0;
            udp_length <= '0;
        end else begin
            for (int i = 0; i < CSUM_OFF; i++)
                if (wr && idx == 3'(i)) hb[i] <= data;
            if (latch) begin
                src_port   <= {hb[SRC_OFF], hb[SRC_OFF+1]};
                dst_port   <= {hb[DST_OFF], hb[DST_OFF+1]};
                udp_length <= len_now;
            end
        end
    end

endmodule

// File: rtl/udp_rx_deframe.sv
// UDP receive deframer: parses the header, filters on destination port and forwards payload.
// Optional macro UDP_LEN_TRUNC_EN ends payload at the length field and discards padding.
module udp_rx_deframe
    import udp_pkg::*;
#(
    parameter udp_port_t LOCAL_PORT = 16'd5000,
    parameter udp_len_t  MIN_LEN    = 16'd8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  udp_rx,
    input  logic        udp_rx_valid,
    input  logic        udp_rx_first,
    input  logic        udp_rx_last,
    output logic [7:0]  to_app,
    output logic        to_app_valid,
    output logic        to_app_first,
    output logic        to_app_last,
    output logic [15:0] src_port,
    output logic [15:0] dst_port,
    output logic [15:0] udp_length,
    output logic        hdr_valid,
    output logic        pkt_dropped,
    output logic        len_error
);

    state_t      state;
    logic [15:0] cnt;
    logic [15:0] cnt_inc;
    logic        pay_first;
    logic        drop_port;
    logic        drop_len;
    logic [15:0] dst_now;
    logic [15:0] len_now;
    logic        hdr_wr;
    logic [2:0]  hdr_idx;
    logic        hdr_latch;

    assign cnt_inc   = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    assign hdr_wr    = udp_rx_valid && (udp_rx_first || state == HDR);
    assign hdr_idx   = udp_rx_first ? 3'd0 : cnt[2:0];
    assign hdr_latch = udp_rx_valid && !udp_rx_first && state == HDR &&
                       cnt == 16'd7 && len_now >= MIN_LEN;

    udp_hdr_capture u_hdr (
        .clk        (clk),
        .rst        (rst),
        .data       (udp_rx),
        .wr         (hdr_wr),
        .idx        (hdr_idx),
        .latch      (hdr_latch),
        .dst_now    (dst_now),
        .len_now    (len_now),
        .src_port   (src_port),
        .dst_port   (dst_port),
        .udp_length (udp_length)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            pay_first    <= 1'b0;
            drop_port    <= 1'b0;
            drop_len     <= 1'b0;
            to_app       <= '0;
            to_app_valid <= 1'b0;
            to_app_first <= 1'b0;
            to_app_last  <= 1'b0;
            hdr_valid    <= 1'b0;
            pkt_dropped  <= 1'b0;
            len_error    <= 1'b0;
        end else begin
            to_app_valid <= 1'b0;
            to_app_first <= 1'b0;
            to_app_last  <= 1'b0;
            hdr_valid    <= 1'b0;
            pkt_dropped  <= 1'b0;
            len_error    <= 1'b0;
            if (udp_rx_valid && udp_rx_first) begin
                // first always restarts; a single-byte packet is a runt
                cnt       <= 16'd1;
                pay_first <= 1'b0;
                drop_port <= 1'b0;
                drop_len  <= 1'b0;
                if (state == PAYLOAD) pkt_dropped <= 1'b1;
                if (udp_rx_last) begin
                    pkt_dropped <= 1'b1;
                    len_error   <= 1'b1;
                    state       <= IDLE;
                end else begin
                    state <= HDR;
                end
            end else if (udp_rx_valid) begin
                case (state)
                    HDR: begin
                        cnt <= cnt_inc;
                        if (udp_rx_last && cnt < 16'd7) begin
                            pkt_dropped <= 1'b1;
                            len_error   <= 1'b1;
                            state       <= IDLE;
                        end else if (cnt == 16'd3 && dst_now != LOCAL_PORT) begin
                            drop_port <= 1'b1;
                            state     <= DROP;
                        end else if (cnt == 16'd7) begin
                            if (len_now < MIN_LEN) begin
                                if (udp_rx_last) begin
                                    len_error <= 1'b1;
                                    state     <= IDLE;
                                end else begin
                                    drop_len <= 1'b1;
                                    state    <= DROP;
                                end
                            end else begin
                                hdr_valid <= 1'b1;
                                if (udp_rx_last) begin
                                    len_error <= (len_now != cnt_inc);
                                    state     <= IDLE;
                                end else if (len_now == 16'(UDP_HDR_BYTES)) begin
                                    // zero-length payload: any surplus is a length error
                                    drop_len <= 1'b1;
                                    state    <= DROP;
                                end else begin
                                    pay_first <= 1'b1;
                                    state     <= PAYLOAD;
                                end
                            end
                        end
                    end
                    PAYLOAD: begin
                        cnt          <= cnt_inc;
                        to_app       <= udp_rx;
                        to_app_valid <= 1'b1;
                        to_app_first <= pay_first;
                        pay_first    <= 1'b0;
`ifdef UDP_LEN_TRUNC_EN
                        if (cnt_inc == udp_length) begin
                            to_app_last <= 1'b1;
                            state       <= udp_rx_last ? IDLE : DROP;
                        end else if (udp_rx_last) begin
                            to_app_last <= 1'b1;
                            len_error   <= 1'b1;
                            state       <= IDLE;
                        end
`else
                        if (udp_rx_last) begin
                            to_app_last <= 1'b1;
                            len_error   <= (cnt_inc != udp_length);
                            state       <= IDLE;
                        end
`endif
                    end
                    DROP: begin
                        cnt <= cnt_inc;
                        if (udp_rx_last) begin
                            pkt_dropped <= drop_port;
                            len_error   <= drop_len;
                            state       <= IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_udp_rx_deframe.sv
// Scoreboard bench for udp_rx_deframe: expected output events are queued per stimulus byte
// and a negedge monitor pops and compares them, including the cycle they appear on.
module tb_udp_rx_deframe;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  udp_rx;
    logic        udp_rx_valid, udp_rx_first, udp_rx_last;
    logic [7:0]  to_app;
    logic        to_app_valid, to_app_first, to_app_last;
    logic [15:0] src_port, dst_port, udp_length;
    logic        hdr_valid, pkt_dropped, len_error;

    udp_rx_deframe dut (
        .clk(clk), .rst(rst),
        .udp_rx(udp_rx), .udp_rx_valid(udp_rx_valid),
        .udp_rx_first(udp_rx_first), .udp_rx_last(udp_rx_last),
        .to_app(to_app), .to_app_valid(to_app_valid),
        .to_app_first(to_app_first), .to_app_last(to_app_last),
        .src_port(src_port), .dst_port(dst_port), .udp_length(udp_length),
        .hdr_valid(hdr_valid), .pkt_dropped(pkt_dropped), .len_error(len_error)
    );

    always #5 clk = ~clk;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        int         seq;
        logic       av;
        logic [7:0] d;
        logic       af, al, hv, pd, le;
    } exp_t;

    exp_t q[$];
    int   sent_cyc[4096];
    int   seq = 0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (!rst && (to_app_valid || hdr_valid || pkt_dropped || len_error)) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output cyc=%0d got av=%b d=%h f=%b l=%b hv=%b pd=%b le=%b required none",
                         cyc, to_app_valid, to_app, to_app_first, to_app_last, hdr_valid, pkt_dropped, len_error);
            end else begin
                e = q.pop_front();
                if (cyc != sent_cyc[e.seq] || to_app_valid !== e.av ||
                    (e.av && to_app !== e.d) || to_app_first !== e.af || to_app_last !== e.al ||
                    hdr_valid !== e.hv || pkt_dropped !== e.pd || len_error !== e.le) begin
                    failures++;
                    $display("FAIL event_seq%0d got cyc=%0d av=%b d=%h f=%b l=%b hv=%b pd=%b le=%b required cyc=%0d av=%b d=%h f=%b l=%b hv=%b pd=%b le=%b",
                             e.seq, cyc, to_app_valid, to_app, to_app_first, to_app_last, hdr_valid, pkt_dropped, len_error,
                             sent_cyc[e.seq], e.av, e.d, e.af, e.al, e.hv, e.pd, e.le);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%h required=%h", nm, got, req);
        end
    endtask

    task automatic ex(input int s, input logic av, input logic [7:0] d,
                      input logic af, input logic al, input logic hv, input logic pd, input logic le);
        exp_t e;
        e.seq = s; e.av = av; e.d = d; e.af = af; e.al = al; e.hv = hv; e.pd = pd; e.le = le;
        q.push_back(e);
    endtask

    task automatic ex_hv(input int s);
        ex(s, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic drive(input logic [7:0] b, input logic f, input logic l);
        @(posedge clk); #1;
        udp_rx = b; udp_rx_valid = 1'b1; udp_rx_first = f; udp_rx_last = l;
        sent_cyc[seq] = cyc + 1;
        seq++;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            udp_rx_valid = 1'b0; udp_rx_first = 1'b0; udp_rx_last = 1'b0;
        end
    endtask

    task automatic send_pkt(input bq_t p, input bit with_last, input int gap);
        for (int i = 0; i < p.size(); i++) begin
            drive(p[i], i == 0, with_last && i == p.size() - 1);
            if (gap > 0 && i != p.size() - 1) idle(gap);
        end
        idle(1);
    endtask

    function automatic bq_t mk_hdr(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l);
        bq_t p;
        p.push_back(s[15:8]); p.push_back(s[7:0]);
        p.push_back(d[15:8]); p.push_back(d[7:0]);
        p.push_back(l[15:8]); p.push_back(l[7:0]);
        p.push_back(8'h00);   p.push_back(8'h00);
        return p;
    endfunction

    task automatic drain(input string nm);
        idle(4);
        chk({nm, "_pending"}, 32'(q.size()), 32'd0);
        q.delete();
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_to_app"},   {24'd0, to_app}, 32'd0);
        chk({nm, "_flags"},    {25'd0, to_app_valid, to_app_first, to_app_last,
                                hdr_valid, pkt_dropped, len_error, 1'b0}, 32'd0);
        chk({nm, "_src"},      {16'd0, src_port}, 32'd0);
        chk({nm, "_dst"},      {16'd0, dst_port}, 32'd0);
        chk({nm, "_len"},      {16'd0, udp_length}, 32'd0);
    endtask

    task automatic exp_p1(input int b);
        ex_hv(b + 7);
        ex(b + 8,  1'b1, 8'hDE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        ex(b + 9,  1'b1, 8'hAD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        ex(b + 10, 1'b1, 8'hBE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        ex(b + 11, 1'b1, 8'hEF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bq_t p1, p, pa;
        int  b;
        rst = 1'b1; udp_rx = '0; udp_rx_valid = 1'b0; udp_rx_first = 1'b0; udp_rx_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        idle(2);

        p1 = mk_hdr(16'h1234, 16'h1388, 16'd12);
        p1.push_back(8'hDE); p1.push_back(8'hAD); p1.push_back(8'hBE); p1.push_back(8'hEF);

        // good packet
        b = seq; exp_p1(b);
        send_pkt(p1, 1'b1, 0);
        drain("good");
        chk("good_src", {16'd0, src_port}, 32'h1234);
        chk("good_dst", {16'd0, dst_port}, 32'h1388);
        chk("good_len", {16'd0, udp_length}, 32'd12);

        // wrong destination port: dropped, fields keep previous header
        p = mk_hdr(16'h5555, 16'h1389, 16'd12);
        p.push_back(8'hDE); p.push_back(8'hAD); p.push_back(8'hBE); p.push_back(8'hEF);
        b = seq; ex(b + 11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send_pkt(p, 1'b1, 0);
        drain("bad_dst");
        chk("bad_dst_src_held", {16'd0, src_port}, 32'h1234);

        // length 12 with 14 bytes on the wire
        p = mk_hdr(16'h0AAA, 16'h1388, 16'd12);
        for (int i = 1; i <= 6; i++) p.push_back(8'(i));
        b = seq; ex_hv(b + 7);
`ifdef UDP_LEN_TRUNC_EN
        ex(b + 8,  1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        ex(b + 9,  1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        ex(b + 10, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        ex(b + 11, 1'b1, 8'h04, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
`else
        ex(b + 8,  1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 2; i <= 5; i++) ex(b + 7 + i, 1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        ex(b + 13, 1'b1, 8'h06, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
`endif
        send_pkt(p, 1'b1, 0);
        drain("long");
        chk("long_src", {16'd0, src_port}, 32'h0AAA);

        // 5-byte runt
        p = mk_hdr(16'h1234, 16'h1388, 16'd12);
        while (p.size() > 5) void'(p.pop_back());
        b = seq; ex(b + 4, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        send_pkt(p, 1'b1, 0);
        drain("runt");

        // packet A aborted mid-payload by packet B
        pa = mk_hdr(16'h0101, 16'h1388, 16'd12);
        pa.push_back(8'h11); pa.push_back(8'h22);
        b = seq; ex_hv(b + 7);
        ex(b + 8, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        ex(b + 9, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        ex(b + 10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        exp_p1(b + 10);
        send_pkt(pa, 1'b0, 0);
        send_pkt(p1, 1'b1, 0);
        drain("abort");
        chk("abort_src", {16'd0, src_port}, 32'h1234);

        // gaps of 3 idle cycles between every byte
        b = seq; exp_p1(b);
        send_pkt(p1, 1'b1, 3);
        drain("gaps");

        // header-only packet
        p = mk_hdr(16'h0007, 16'h1388, 16'd8);
        b = seq; ex_hv(b + 7);
        send_pkt(p, 1'b1, 0);
        drain("hdr_only");
        chk("hdr_only_len", {16'd0, udp_length}, 32'd8);

        // zero-length header followed by surplus bytes
        p = mk_hdr(16'h0008, 16'h1388, 16'd8);
        p.push_back(8'hAA); p.push_back(8'hBB);
        b = seq; ex_hv(b + 7);
        ex(b + 9, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        send_pkt(p, 1'b1, 0);
        drain("surplus");

        // reset in the middle of a payload
        p = mk_hdr(16'h4321, 16'h1388, 16'd12);
        p.push_back(8'h55);
        b = seq; ex_hv(b + 7);
        ex(b + 8, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send_pkt(p, 1'b0, 0);
        chk("pre_rst_src", {16'd0, src_port}, 32'h4321);
        drive(8'h66, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_all_zero("mid_rst");
        rst = 1'b0;
        drain("mid_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
